// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants and types for the CPU front end.
//            - default reset PC and NOP instruction word
//            - fetch FSM state encoding
//            - IF/ID entry type (PC + instruction), also used by the skid buffer
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [15:0] DEFAULT_NOP_INST = 16'h0000;

  // Fetch FSM state encoding
  localparam int FETCH_STATE_W = 2;
  typedef logic [FETCH_STATE_W-1:0] fetch_state_t;

  localparam fetch_state_t FETCH_IDLE = 2'd0;  // no request outstanding
  localparam fetch_state_t FETCH_WAIT = 2'd1;  // request outstanding, response wanted
  localparam fetch_state_t FETCH_HOLD = 2'd2;  // response parked in skid buffer
  localparam fetch_state_t FETCH_DROP = 2'd3;  // request outstanding, response discarded

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } ifid_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register. Priority: reset > flush > stall > load.
//            When neither stalled nor loaded, the entry is marked invalid so a
//            consumed instruction is never presented to decode twice.
// Ports    : clk, reset_n        - clock, synchronous active-low reset
//            load, pc_in, inst_in - new entry from fetch
//            stall, flush         - hazard controls
//            pcD, instD, validD   - decode-side view of the entry
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [15:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] pc_in,
  input  logic [15:0] inst_in,
  output logic [15:0] pcD,
  output logic [15:0] instD,
  output logic        validD
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcD    <= 16'h0000;
      instD  <= NOP_INST;
      validD <= 1'b0;
    end else if (flush) begin
      // Bubble: pcD intentionally left alone
      instD  <= NOP_INST;
      validD <= 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (load) begin
      pcD    <= pc_in;
      instD  <= inst_in;
      validD <= 1'b1;
    end else begin
      validD <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage: PC, fetch FSM, one-entry skid buffer and
//            the IF/ID register. At most one memory request outstanding.
// Ports    : clk, reset_n              - clock, synchronous active-low reset
//            stallF, stallD, flushD    - hazard unit controls
//            InstBranch, branch_target - taken-branch redirect
//            imem_req, imem_addr       - instruction memory request
//            imem_ready, imem_rdata    - instruction memory response
//            pcD, instD, validD        - instruction handed to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [15:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        InstBranch,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pcD,
  output logic [15:0] instD,
  output logic        validD
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [15:0]  pcF;
  logic [15:0]  drop_addr;   // address of the request being discarded
  ifid_entry_t  skid;
  logic         skid_valid;

  logic         resp_take;   // accepted response in WAIT (not redirected)
  logic         skid_release;
  logic         ifid_load;
  ifid_entry_t  ifid_in;

  assign resp_take    = (state == FETCH_WAIT) && imem_ready && !InstBranch;
  assign skid_release = (state == FETCH_HOLD) && skid_valid && !stallD && !InstBranch;
  assign ifid_load    = (resp_take && !stallD) || skid_release;
  assign ifid_in      = (state == FETCH_HOLD) ? skid : '{pc: pcF, inst: imem_rdata};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: begin
        if (!stallF) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (InstBranch) begin
          // The in-flight request belongs to the wrong path
          state_next = imem_ready ? FETCH_IDLE : FETCH_DROP;
        end else if (imem_ready) begin
          if (stallD)      state_next = FETCH_HOLD;
          else if (stallF) state_next = FETCH_IDLE;
          else             state_next = FETCH_WAIT;
        end
      end
      FETCH_HOLD: begin
        if (InstBranch || !stallD) state_next = FETCH_IDLE;
      end
      FETCH_DROP: begin
        if (imem_ready) state_next = FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req  = (state == FETCH_WAIT) || (state == FETCH_DROP);
    // pcF already points at the branch target while DROP waits out the old
    // request, so the old address is replayed to keep the request stable.
    imem_addr = (state == FETCH_DROP) ? drop_addr : pcF;
  end

  // --------------------------------------------------------------------------
  // PC, drop address and skid buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcF        <= RESET_PC;
      drop_addr  <= RESET_PC;
      skid       <= '{pc: 16'h0000, inst: NOP_INST};
      skid_valid <= 1'b0;
    end else begin
      if (InstBranch) begin
        pcF <= branch_target;
      end else if (resp_take) begin
        pcF <= pcF + 16'h0001;  // wraps naturally at 16 bits
      end

      if ((state == FETCH_WAIT) && InstBranch && !imem_ready) begin
        drop_addr <= pcF;
      end

      if (resp_take && stallD) begin
        skid       <= '{pc: pcF, inst: imem_rdata};
        skid_valid <= 1'b1;
      end else if ((state == FETCH_HOLD) && (InstBranch || !stallD)) begin
        skid_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID register
  // --------------------------------------------------------------------------
  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ifid_load),
    .stall   (stallD),
    .flush   (flushD),
    .pc_in   (ifid_in.pc),
    .inst_in (ifid_in.inst),
    .pcD     (pcD),
    .instD   (instD),
    .validD  (validD)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage. Memory model
//            returns imem_addr + 16'h1000 as the instruction word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hE000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stallF, stallD, flushD, InstBranch;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] pcD, instD;
  logic        validD;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 16'h1000;

  fetch_stage #(
    .RESET_PC (16'h0000),
    .NOP_INST (NOP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stallF        (stallF),
    .stallD        (stallD),
    .flushD        (flushD),
    .InstBranch    (InstBranch),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pcD           (pcD),
    .instD         (instD),
    .validD        (validD)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; observe 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    InstBranch = 1'b0; branch_target = 16'h0000; imem_ready = 1'b0;
    tick(); tick();
    check("rst_req",   imem_req, 0);
    check("rst_valid", validD, 0);
    check("rst_pcD",   pcD, 16'h0000);
    check("rst_instD", instD, NOP);

    // ---- streaming with ready tied high ----
    imem_ready = 1'b1;
    reset_n    = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stream_req",  imem_req, 1);
      check("stream_addr", imem_addr, i);
      if (i > 0) begin
        check("stream_inst",  instD, 16'h1000 + i - 1);
        check("stream_pcD",   pcD, i - 1);
        check("stream_valid", validD, 1);
      end
      tick();
    end
    check("stream_inst3", instD, 16'h1003);
    check("stream_addr4", imem_addr, 16'h0004);

    // ---- delayed ready at 0x0005 ----
    tick();
    imem_ready = 1'b0;
    load_cnt   = 0;
    for (int k = 0; k < 4; k++) begin
      check("wait_addr", imem_addr, 16'h0005);
      check("wait_req",  imem_req, 1);
      if (validD && pcD == 16'h0005) load_cnt++;
      if (k == 3) imem_ready = 1'b1;
      tick();
    end
    imem_ready = 1'b0;
    check("wait_inst", instD, 16'h1005);
    for (int k = 0; k < 3; k++) begin
      if (validD && pcD == 16'h0005) load_cnt++;
      tick();
    end
    check("wait_loads", load_cnt, 1);

    // ---- decode stall while response 0x0007 arrives ----
    imem_ready = 1'b1;
    tick();                          // loads 0x0006, addr now 0x0007
    stallD = 1'b1;
    tick();
    check("hold_req",  imem_req, 0);
    check("hold_inst", instD, 16'h1006);
    imem_ready = 1'b0;
    tick();
    check("hold_req2",  imem_req, 0);
    check("hold_inst2", instD, 16'h1006);
    stallD = 1'b0;
    tick();
    check("rel_inst",  instD, 16'h1007);
    check("rel_pcD",   pcD, 16'h0007);
    check("rel_valid", validD, 1);
    tick();
    check("rel_addr",  imem_addr, 16'h0008);
    check("rel_nodup", validD, 0);

    // ---- branch with pending response -> DROP ----
    InstBranch = 1'b1; branch_target = 16'h0040;
    tick();
    InstBranch = 1'b0;
    check("drop_req",  imem_req, 1);
    check("drop_addr", imem_addr, 16'h0008);
    imem_ready = 1'b1;               // response for 0x0008 must be discarded
    tick();
    imem_ready = 1'b0;
    check("drop_idle",  imem_req, 0);
    check("drop_inst",  instD, 16'h1007);
    check("drop_valid", validD, 0);
    tick();
    check("tgt_addr", imem_addr, 16'h0040);
    imem_ready = 1'b1; flushD = 1'b1;
    tick();
    check("flush_inst",  instD, NOP);
    check("flush_valid", validD, 0);
    check("flush_pcD",   pcD, 16'h0007);
    check("flush_addr",  imem_addr, 16'h0041);

    // ---- branch to 0xFFFF with response ready, then wrap ----
    flushD = 1'b0; InstBranch = 1'b1; branch_target = 16'hFFFF;
    tick();
    InstBranch = 1'b0;
    check("br_rdy_req",   imem_req, 0);
    check("br_rdy_valid", validD, 0);
    tick();
    check("wrap_addr0", imem_addr, 16'hFFFF);
    tick();
    check("wrap_addr1", imem_addr, 16'h0000);
    check("wrap_inst",  instD, 16'h0FFF);
    check("wrap_pcD",   pcD, 16'hFFFF);

    // ---- flush and stall together: flush wins ----
    flushD = 1'b1; stallD = 1'b1;
    tick();
    check("fs_inst",  instD, NOP);
    check("fs_valid", validD, 0);
    check("fs_pcD",   pcD, 16'hFFFF);
    check("fs_req",   imem_req, 0);
    flushD = 1'b0; stallD = 1'b0;
    tick();
    check("fs_rel_inst", instD, 16'h1000);
    check("fs_rel_pcD",  pcD, 16'h0000);
    tick();
    imem_ready = 1'b0;
    tick();
    check("pre_rst_addr", imem_addr, 16'h0001);

    // ---- reset mid-WAIT, then late ready in IDLE ----
    reset_n = 1'b0;
    tick();
    check("mrst_req",   imem_req, 0);
    check("mrst_pcD",   pcD, 16'h0000);
    check("mrst_instD", instD, NOP);
    check("mrst_valid", validD, 0);
    reset_n = 1'b1; imem_ready = 1'b1; stallF = 1'b1;
    tick();
    check("late_req",   imem_req, 0);
    check("late_valid", validD, 0);
    stallF = 1'b0;
    tick();
    check("post_rst_addr", imem_addr, 16'h0000);
    check("post_rst_req",  imem_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded at reset.
REQ-002 The block SHALL have parameter NOP_INST, default 16'h0000, meaning the instruction word injected into decode on flush.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- stallF  in  1  hazard unit: hold PC, issue no new fetch.
- stallD  in  1  hazard unit: hold IF/ID register.
- flushD  in  1  hazard unit: replace IF/ID contents with a bubble.
- InstBranch  in  1  hazard unit: taken branch, redirect PC.
- branch_target  in  16  redirect address, valid with InstBranch.
- imem_req  out  1  instruction memory request.
- imem_addr  out  16  request address (word address).
- imem_ready  in  1  memory response; imem_rdata valid this cycle.
- imem_rdata  in  16  instruction word.
- pcD  out  16  PC of instruction in decode.
- instD  out  16  instruction in decode.
- validD  out  1  instD holds a real instruction.

Function
REQ-005 The FSM SHALL have states IDLE, WAIT, HOLD and DROP; reset state IDLE.
REQ-006 imem_req SHALL be 1 exactly in WAIT or DROP; imem_addr SHALL equal pcF and stay stable while imem_req=1 and imem_ready=0.
REQ-007 IDLE: if !stallF -> WAIT; else stay.
REQ-008 WAIT, imem_ready=1, InstBranch=0, stallD=0: load IF/ID {pcD=pcF, instD=imem_rdata, validD=1}, pcF<=pcF+1, stay WAIT if !stallF else IDLE.
REQ-009 WAIT, imem_ready=1, InstBranch=0, stallD=1: capture {pcF, imem_rdata} in a one-entry skid buffer, pcF<=pcF+1, go HOLD.
REQ-010 HOLD: when stallD=0, move skid buffer to IF/ID with validD=1, go IDLE; imem_req=0 throughout HOLD.
REQ-011 InstBranch=1 SHALL load pcF<=branch_target in that cycle, with priority over stallF and over increment.
REQ-012 InstBranch in WAIT with imem_ready=0 -> DROP; in DROP the response on imem_ready is discarded, then IDLE.
REQ-013 InstBranch in WAIT with imem_ready=1 SHALL discard the response and go IDLE.
REQ-014 InstBranch in HOLD SHALL invalidate the skid buffer and go IDLE.
REQ-015 flushD SHALL set instD=NOP_INST, validD=0 and pcD unchanged, with priority over stallD and over any IF/ID load in the same cycle.
REQ-016 stallD=1 and flushD=0 SHALL hold pcD, instD and validD unchanged.
REQ-017 pcF increment SHALL be modulo 2^16 (16'hFFFF -> 16'h0000), with no flag.
REQ-018 At most one memory transaction SHALL be outstanding; a response is never delivered twice or out of order.
REQ-019 Fetch-to-decode latency SHALL be one cycle after imem_ready; with imem_ready tied 1 and no hazards, throughput SHALL be one instruction per cycle after the first IDLE->WAIT cycle.

Reset
REQ-020 On clk rising edge with reset_n=0: state=IDLE, pcF=RESET_PC, pcD=16'h0000, instD=NOP_INST, validD=0, skid buffer empty; imem_req=0 follows combinationally.
REQ-021 Reset mid-transaction SHALL abandon the outstanding request; a late imem_ready after reset release while in IDLE SHALL be ignored.

Structure
REQ-022 NOP_INST, RESET_PC and the fetch FSM state encoding SHALL live in shared package cpu_pkg.
REQ-023 The IF/ID register (load / hold / flush priority) SHALL be sub-module if_id_reg; the FSM, PC and skid buffer SHALL stay in fetch_stage.

Verification
REQ-024 Reset, imem_ready tied 1, rdata=addr+16'h1000 -> addresses 0,1,2,3 on consecutive cycles; instD 16'h1000,16'h1001,... one cycle later; validD=1.
REQ-025 imem_ready delayed 3 cycles -> imem_addr held at 0x0005 for all 4 req cycles; exactly one IF/ID load.
REQ-026 stallD=1 for 2 cycles as response 0x0007 arrives -> HOLD, imem_req=0; instD=inst@0x0007 the cycle after stallD drops; no loss or duplicate.
REQ-027 InstBranch=1, branch_target=0x0040 while WAIT with pending response -> DROP; dropped rdata never reaches instD; next imem_addr=0x0040; flushD gives instD=NOP_INST, validD=0.
REQ-028 pcF=0xFFFF with ready -> next imem_addr=0x0000; flushD and stallD both 1 -> flush wins; reset_n=0 mid-WAIT -> all outputs at REQ-020 values.
